// File: rtl/spi_slave_16_if.sv
// Pin and handshake bundle for spi_slave_16: SPI pins plus the tx holding-buffer
// handshake and the rx/status strobes.
interface spi_slave_16_if;
  logic        sck;
  logic        ss_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        underrun;
  logic        frame_err;
  logic        busy;

  // The responder itself.
  modport slave (
    input  sck, ss_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_err, busy
  );

  // Whatever drives the responder: SPI master plus the tx producer / rx consumer.
  modport master (
    output sck, ss_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_16.sv
// spi_slave_16: mode-0 (CPOL=0, CPHA=0) SPI responder, 16-bit words, MSB first.
// Oversamples the SPI pins in the clk domain; tx words come from a one-entry
// holding buffer, rx words are presented with a one-cycle strobe.
module spi_slave_16 #(
  // Synchronizer depth on sck/ss_n/mosi; legal values 2..3.
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  spi_slave_16_if.slave bus_io
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise, sck_fall, ss_rise, ss_fall;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rx_shift_q, rx_shift_d;
  logic [15:0] tx_shift_q, tx_shift_d;
  logic [15:0] buf_q, buf_d;
  logic        buf_full_q, buf_full_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        underrun_q, underrun_d;
  logic        frame_err_q, frame_err_d;

  logic        load;
  logic        buf_wr;
  logic [15:0] rx_next;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;

  assign rx_next = {rx_shift_q[14:0], mosi_s};
  // The write is qualified by the pre-load buffer state: a write that collides
  // with a load from an empty buffer is kept for the next load.
  assign buf_wr  = bus_io.tx_valid & ~buf_full_q;

  // Synchronizers and edge-detect history. The ss_n chain resets low so that a
  // select still held low across reset never looks like a fresh falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus_io.sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus_io.ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus_io.mosi};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  // Next-state: frame FSM, shifters, word loads and the holding buffer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    load        = 1'b0;

    case (state_q)
      StIdle: begin
        // sck edges are ignored here; only a select starts a frame.
        if (ss_fall) begin
          state_d    = StActive;
          cnt_d      = 4'd0;
          rx_shift_d = '0;
          load       = 1'b1;
        end
      end
      StActive: begin
        // ss edges take priority over a coincident sck edge.
        if (ss_rise) begin
          state_d     = StIdle;
          frame_err_d = (cnt_q != 4'd0);
          cnt_d       = 4'd0;
          rx_shift_d  = '0;
          tx_shift_d  = '0;
        end else if (sck_rise) begin
          rx_shift_d = rx_next;
          cnt_d      = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
          end
        end else if (sck_fall) begin
          // A fall at count 0 is a word boundary: fetch the next word.
          if (cnt_q != 4'd0) begin
            tx_shift_d = {tx_shift_q[14:0], 1'b0};
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end

    if (buf_wr) begin
      buf_d      = bus_io.tx_data;
      buf_full_d = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Outputs. tx_ready reads 1 throughout reset, not only after the first edge.
  assign bus_io.miso      = (state_q == StActive) & tx_shift_q[15];
  assign bus_io.miso_oe   = (state_q == StActive);
  assign bus_io.busy      = (state_q == StActive);
  assign bus_io.tx_ready  = rst | ~buf_full_q;
  assign bus_io.rx_data   = rx_data_q;
  assign bus_io.rx_valid  = rx_valid_q;
  assign bus_io.underrun  = underrun_q;
  assign bus_io.frame_err = frame_err_q;

endmodule
